// File: rtl/snn_cmd_pkg.sv
// Shared constants, FSM state type and the config entry layout for the SNN command sequencer.
package snn_cmd_pkg;

    localparam int unsigned INT_WIDTH   = 4;
    localparam int unsigned FLOAT_WIDTH = 2 * INT_WIDTH;
    localparam int unsigned ADDR_WIDTH  = 3;
    localparam int unsigned CMD_WIDTH   = 3;

    // Network commands live at the top of the cmd encoding space; 0 means "run".
    localparam logic [CMD_WIDTH-1:0] CMD_SET_DELIVERY_TIME = '1;
    localparam logic [CMD_WIDTH-1:0] CMD_SET_BIAS          = ~CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] CMD_CLEAR             = ~CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] CMD_RUN               = '0;

    typedef enum logic [2:0] {
        StIdle,
        StProgram,
        StClear,
        StRun,
        StReport
    } seq_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  addr;
        logic [CMD_WIDTH-1:0]   cmd;
        logic [FLOAT_WIDTH-1:0] arg;
    } cfg_entry_t;

    function automatic logic is_cfg_cmd(input logic [CMD_WIDTH-1:0] cmd);
        return (cmd == CMD_SET_DELIVERY_TIME) || (cmd == CMD_SET_BIAS);
    endfunction

endpackage

// File: rtl/snn_cmd_sequencer_if.sv
// Host-side configuration channel: valid/ready handshake carrying one neuron config entry.
interface snn_cmd_sequencer_if;

    logic                                cfg_valid;
    logic                                cfg_ready;
    logic [snn_cmd_pkg::ADDR_WIDTH-1:0]  cfg_addr;
    logic [snn_cmd_pkg::CMD_WIDTH-1:0]   cfg_cmd;
    logic [snn_cmd_pkg::FLOAT_WIDTH-1:0] cfg_arg;

    modport master (
        output cfg_valid,
        output cfg_addr,
        output cfg_cmd,
        output cfg_arg,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_addr,
        input  cfg_cmd,
        input  cfg_arg,
        output cfg_ready
    );

endinterface

// File: rtl/snn_cfg_fifo.sv
// Synchronous first-word-fall-through FIFO of config entries with full/empty flags.
module snn_cfg_fifo
    import snn_cmd_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  cfg_entry_t i_wdata,
    input  logic       i_pop,
    output cfg_entry_t o_rdata,
    output logic       o_full,
    output logic       o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    cfg_entry_t  r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_do_push;
    logic        w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/snn_cmd_sequencer.sv
// Command-bus initiator: replays buffered config onto the network bus, clears it, runs a
// timed inference and reports one decision (or a timeout) per accepted start.
module snn_cmd_sequencer
    import snn_cmd_pkg::*;
#(
    parameter int unsigned MAX_TIME   = 35,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RUN_GUARD  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    snn_cmd_sequencer_if.slave     i_cfg,
    input  logic                   i_start,
    input  logic                   i_in1_req,
    input  logic                   i_in2_req,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_result,
    output logic [31:0]            o_result_time,
    output logic                   o_timeout,
    output logic                   o_cfg_err,
    output logic [ADDR_WIDTH-1:0]  o_net_addr,
    output logic [CMD_WIDTH-1:0]   o_net_cmd,
    output logic [FLOAT_WIDTH-1:0] o_net_arg,
    output logic                   o_net_in1,
    output logic                   o_net_in2,
    input  logic                   i_net_out,
    input  logic [31:0]            i_net_out_time
);

    localparam int unsigned RUN_LIMIT   = MAX_TIME + RUN_GUARD - 1;
    localparam int unsigned CNT_W       = $clog2(MAX_TIME + RUN_GUARD + 1);
    localparam logic [31:0] NO_DECISION = 32'(MAX_TIME);

    seq_state_t             r_state;
    logic [ADDR_WIDTH-1:0]  r_net_addr;
    logic [CMD_WIDTH-1:0]   r_net_cmd;
    logic [FLOAT_WIDTH-1:0] r_net_arg;
    logic                   r_net_in1;
    logic                   r_net_in2;
    logic                   r_in1_lat;
    logic                   r_in2_lat;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_result;
    logic [31:0]            r_result_time;
    logic                   r_timeout;
    logic                   r_cfg_err;
    logic [CNT_W-1:0]       r_run_cnt;

    cfg_entry_t w_wdata;
    cfg_entry_t w_head;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_cfg_ready;
    logic       w_push;
    logic       w_pop;
    logic       w_decided;
    logic       w_expired;

    // Config is frozen while draining so the programming burst is a stable snapshot.
    assign w_cfg_ready     = !w_fifo_full && (r_state != StProgram);
    assign i_cfg.cfg_ready = w_cfg_ready;
    assign w_push          = i_cfg.cfg_valid && w_cfg_ready;
    assign w_pop           = (r_state == StProgram) && !w_fifo_empty;
    assign w_wdata         = '{addr: i_cfg.cfg_addr, cmd: i_cfg.cfg_cmd, arg: i_cfg.cfg_arg};

    // The network parks out_time at MAX_TIME until it decides (early or at horizon+10).
    assign w_decided = (i_net_out_time != NO_DECISION);
    assign w_expired = (r_run_cnt == CNT_W'(RUN_LIMIT));

    snn_cfg_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cfg_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_net_addr    <= '0;
            r_net_cmd     <= CMD_CLEAR;
            r_net_arg     <= '0;
            r_net_in1     <= 1'b0;
            r_net_in2     <= 1'b0;
            r_in1_lat     <= 1'b0;
            r_in2_lat     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_result      <= 1'b0;
            r_result_time <= '0;
            r_timeout     <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_run_cnt     <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_in1_lat <= i_in1_req;
                        r_in2_lat <= i_in2_req;
                        r_timeout <= 1'b0;
                        r_cfg_err <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= w_fifo_empty ? StClear : StProgram;
                    end
                end
                StProgram: begin
                    if (!w_fifo_empty) begin
                        if (is_cfg_cmd(w_head.cmd)) begin
                            r_net_addr <= w_head.addr;
                            r_net_cmd  <= w_head.cmd;
                            r_net_arg  <= w_head.arg;
                        end else begin
                            r_net_addr <= '0;
                            r_net_cmd  <= CMD_CLEAR;
                            r_net_arg  <= '0;
                            r_cfg_err  <= 1'b1;
                        end
                    end else begin
                        r_net_addr <= '0;
                        r_net_cmd  <= CMD_CLEAR;
                        r_net_arg  <= '0;
                        r_state    <= StClear;
                    end
                end
                StClear: begin
                    r_net_addr <= '0;
                    r_net_cmd  <= CMD_RUN;
                    r_net_arg  <= '0;
                    r_net_in1  <= r_in1_lat;
                    r_net_in2  <= r_in2_lat;
                    r_run_cnt  <= '0;
                    r_state    <= StRun;
                end
                StRun: begin
                    if (w_decided || w_expired) begin
                        r_result      <= w_decided && i_net_out;
                        r_result_time <= w_decided ? i_net_out_time : '1;
                        r_timeout     <= !w_decided;
                        r_done        <= 1'b1;
                        r_busy        <= 1'b0;
                        r_net_cmd     <= CMD_CLEAR;
                        r_net_in1     <= 1'b0;
                        r_net_in2     <= 1'b0;
                        r_state       <= StReport;
                    end else begin
                        r_run_cnt <= r_run_cnt + CNT_W'(1);
                    end
                end
                StReport: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_result      = r_result;
    assign o_result_time = r_result_time;
    assign o_timeout     = r_timeout;
    assign o_cfg_err     = r_cfg_err;
    assign o_net_addr    = r_net_addr;
    assign o_net_cmd     = r_net_cmd;
    assign o_net_arg     = r_net_arg;
    assign o_net_in1     = r_net_in1;
    assign o_net_in2     = r_net_in2;

endmodule

// File: tb/tb_snn_cmd_sequencer.sv
// Scoreboard bench for snn_cmd_sequencer driven against a small behavioural network stub.
module tb_snn_cmd_sequencer;
    import snn_cmd_pkg::*;

    localparam int unsigned MAX_TIME  = 35;
    localparam int unsigned RUN_GUARD = 4;

    typedef struct {
        logic        res;
        logic [31:0] t;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, in1_req, in2_req;
    logic        busy, done, result, timeout, cfg_err;
    logic [31:0] result_time;
    logic [2:0]  net_addr, net_cmd;
    logic [7:0]  net_arg;
    logic        net_in1, net_in2, net_out;
    logic [31:0] net_out_time;

    int          stub_cnt = 0;
    bit          stub_decide;
    int          stub_at;
    logic        stub_out;
    logic [31:0] stub_time;

    exp_t        sb_q[$];
    cfg_entry_t  bus_q[$];
    logic [2:0]  trace_q[$];
    int          run_cycles;
    logic        exp_in1, exp_in2;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    snn_cmd_sequencer_if cfg_if();

    snn_cmd_sequencer #(
        .MAX_TIME   (MAX_TIME),
        .FIFO_DEPTH (8),
        .RUN_GUARD  (RUN_GUARD)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cfg          (cfg_if),
        .i_start        (start),
        .i_in1_req      (in1_req),
        .i_in2_req      (in2_req),
        .o_busy         (busy),
        .o_done         (done),
        .o_result       (result),
        .o_result_time  (result_time),
        .o_timeout      (timeout),
        .o_cfg_err      (cfg_err),
        .o_net_addr     (net_addr),
        .o_net_cmd      (net_cmd),
        .o_net_arg      (net_arg),
        .o_net_in1      (net_in1),
        .o_net_in2      (net_in2),
        .i_net_out      (net_out),
        .i_net_out_time (net_out_time)
    );

    // Stub network: counts run cycles, reports MAX_TIME until its decision point.
    always @(posedge clk) stub_cnt <= (net_cmd == 3'd0) ? stub_cnt + 1 : 0;
    assign net_out_time = (stub_decide && stub_cnt >= stub_at) ? stub_time : 32'(MAX_TIME);
    assign net_out      = stub_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_stub(input bit dec, input int at, input logic o, input logic [31:0] t);
        stub_decide = dec;
        stub_at     = at;
        stub_out    = o;
        stub_time   = t;
    endtask

    task automatic push_cfg(input logic [2:0] a, input logic [2:0] c, input logic [7:0] arg);
        bit ok = 0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = a;
        cfg_if.cfg_cmd   = c;
        cfg_if.cfg_arg   = arg;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (cfg_if.cfg_ready === 1'b1) ok = 1;
            tick();
        end
        cfg_if.cfg_valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL push_accept: cfg_ready never 1 for addr %0d, required 1", a);
        end else if (c == 3'd7 || c == 3'd6) begin
            bus_q.push_back('{addr: a, cmd: c, arg: arg});
        end
    endtask

    task automatic do_start(input logic i1, input logic i2, input logic r, input logic [31:0] t,
                            input logic to);
        sb_q.push_back('{res: r, t: t, to: to});
        exp_in1 = i1;
        exp_in2 = i2;
        trace_q.delete();
        run_cycles = 0;
        in1_req = i1;
        in2_req = i2;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        in1_req = ~i1;
        in2_req = ~i2;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_busy: busy=%b, required 1", busy);
        end
    endtask

    task automatic wait_done(input string name, input int pulse_at);
        bit   seen = 0;
        bit   in_ok = 1;
        exp_t ex;
        cfg_entry_t e;
        for (int k = 0; k < 300 && !seen; k++) begin
            start = (k == pulse_at);
            tick();
            trace_q.push_back(net_cmd);
            if (net_cmd === 3'd0) begin
                run_cycles++;
                if (net_in1 !== exp_in1 || net_in2 !== exp_in2) in_ok = 0;
            end else if (net_cmd !== 3'd5) begin
                n_cmp++;
                if (bus_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s_bus: unexpected entry %0h/%0h/%0h, required none",
                             name, net_addr, net_cmd, net_arg);
                end else begin
                    e = bus_q.pop_front();
                    if ({net_addr, net_cmd, net_arg} !== e) begin
                        n_err++;
                        $display("FAIL %s_bus: got %0h/%0h/%0h, required %0h/%0h/%0h", name,
                                 net_addr, net_cmd, net_arg, e.addr, e.cmd, e.arg);
                    end
                end
            end
            if (done === 1'b1) begin
                seen = 1;
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s_sb: done with no expected result, required none", name);
                end else begin
                    ex = sb_q.pop_front();
                    n_cmp += 4;
                    if (result !== ex.res) begin
                        n_err++;
                        $display("FAIL %s_result: got %b, required %b", name, result, ex.res);
                    end
                    if (result_time !== ex.t) begin
                        n_err++;
                        $display("FAIL %s_time: got %0h, required %0h", name, result_time, ex.t);
                    end
                    if (timeout !== ex.to) begin
                        n_err++;
                        $display("FAIL %s_timeout: got %b, required %b", name, timeout, ex.to);
                    end
                    if (busy !== 1'b0) begin
                        n_err++;
                        $display("FAIL %s_busy_at_done: got %b, required 0", name, busy);
                    end
                end
            end
        end
        start = 1'b0;
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_done: no done within 300 cycles, required a pulse", name);
        end
        n_cmp++;
        if (!in_ok) begin
            n_err++;
            $display("FAIL %s_operands: net_in1/2 differed from %b/%b in run", name, exp_in1,
                     exp_in2);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL %s_done_width: done=%b one cycle later, required 0", name, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp += 12;
        if (net_cmd !== 3'd5) begin n_err++; $display("FAIL rst_cmd: got %0d, required 5", net_cmd); end
        if (net_addr !== 3'd0) begin n_err++; $display("FAIL rst_addr: got %0d, required 0", net_addr); end
        if (net_arg !== 8'd0) begin n_err++; $display("FAIL rst_arg: got %0h, required 0", net_arg); end
        if (net_in1 !== 1'b0) begin n_err++; $display("FAIL rst_in1: got %b, required 0", net_in1); end
        if (net_in2 !== 1'b0) begin n_err++; $display("FAIL rst_in2: got %b, required 0", net_in2); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b, required 0", done); end
        if (result !== 1'b0) begin n_err++; $display("FAIL rst_result: got %b, required 0", result); end
        if (result_time !== 32'd0) begin n_err++; $display("FAIL rst_rtime: got %0h, required 0", result_time); end
        if (timeout !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %b, required 0", timeout); end
        if (cfg_err !== 1'b0) begin n_err++; $display("FAIL rst_cfg_err: got %b, required 0", cfg_err); end
        if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b, required 1", cfg_if.cfg_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_empty_run();
        set_stub(1, 3, 1'b1, 32'd12);
        do_start(1'b1, 1'b0, 1'b1, 32'd12, 1'b0);
        wait_done("empty_run", -1);
        n_cmp++;
        if (cfg_err !== 1'b0) begin
            n_err++;
            $display("FAIL empty_run_cfg_err: got %b, required 0", cfg_err);
        end
    endtask

    task automatic test_program_order();
        int first = -1;
        bit ok;
        set_stub(1, 2, 1'b0, 32'(MAX_TIME + 10));
        push_cfg(3'd1, 3'd6, 8'h10);
        push_cfg(3'd2, 3'd6, 8'h10);
        push_cfg(3'd4, 3'd6, 8'h10);
        do_start(1'b1, 1'b1, 1'b0, 32'(MAX_TIME + 10), 1'b0);
        wait_done("program", -1);
        foreach (trace_q[i]) if (first < 0 && (trace_q[i] == 3'd6 || trace_q[i] == 3'd7)) first = i;
        ok = (first >= 0) && (first + 4 < trace_q.size());
        if (ok) ok = (trace_q[first + 1] == 3'd6) && (trace_q[first + 2] == 3'd6) &&
                     (trace_q[first + 3] == 3'd5) && (trace_q[first + 4] == 3'd0);
        n_cmp += 2;
        if (!ok) begin
            n_err++;
            $display("FAIL program_sequence: first prog at %0d, required 3 prog, 1 CLEAR, then 0",
                     first);
        end
        if (bus_q.size() != 0) begin
            n_err++;
            $display("FAIL program_drained: %0d entries left, required 0", bus_q.size());
        end
    endtask

    task automatic test_timeout();
        set_stub(0, 0, 1'b1, 32'd0);
        do_start(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
        wait_done("timeout", -1);
        n_cmp++;
        if (run_cycles != int'(MAX_TIME + RUN_GUARD)) begin
            n_err++;
            $display("FAIL timeout_cycles: got %0d run cycles, required %0d", run_cycles,
                     MAX_TIME + RUN_GUARD);
        end
    endtask

    task automatic test_cfg_err();
        set_stub(1, 5, 1'b1, 32'd20);
        push_cfg(3'd3, 3'd5, 8'h55);
        push_cfg(3'd6, 3'd1, 8'h33);
        push_cfg(3'd5, 3'd7, 8'h22);
        do_start(1'b0, 1'b0, 1'b1, 32'd20, 1'b0);
        wait_done("cfg_err", -1);
        n_cmp += 2;
        if (cfg_err !== 1'b1) begin
            n_err++;
            $display("FAIL cfg_err_flag: got %b, required 1", cfg_err);
        end
        if (bus_q.size() != 0) begin
            n_err++;
            $display("FAIL cfg_err_drained: %0d entries left, required 0", bus_q.size());
        end
    endtask

    task automatic test_full_and_busy();
        bit held = 1;
        bit idle = 1;
        set_stub(1, 2, 1'b1, 32'd7);
        for (int i = 0; i < 8; i++)
            push_cfg(3'(i), (i % 2) ? 3'd7 : 3'd6, 8'(i * 17 + 3));
        n_cmp += 3;
        if (cfg_if.cfg_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_ready: got %b, required 0", cfg_if.cfg_ready);
        end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = 3'd7;
        cfg_if.cfg_cmd   = 3'd6;
        cfg_if.cfg_arg   = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (cfg_if.cfg_ready !== 1'b0) held = 0;
        end
        cfg_if.cfg_valid = 1'b0;
        if (!held) begin
            n_err++;
            $display("FAIL full_hold: cfg_ready rose while full, required 0");
        end
        if (cfg_err !== 1'b1) begin
            n_err++;
            $display("FAIL cfg_err_sticky: got %b, required 1", cfg_err);
        end
        do_start(1'b1, 1'b0, 1'b1, 32'd7, 1'b0);
        wait_done("full_busy", 3);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0) idle = 0;
        end
        n_cmp += 3;
        if (!idle) begin
            n_err++;
            $display("FAIL busy_start_ignored: busy/done rose after run, required 0");
        end
        if (cfg_err !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_err_cleared: got %b, required 0", cfg_err);
        end
        if (bus_q.size() != 0) begin
            n_err++;
            $display("FAIL full_drained: %0d entries left, required 0", bus_q.size());
        end
    endtask

    task automatic test_reset_mid_run();
        bit in_run = 0;
        set_stub(0, 0, 1'b0, 32'd0);
        push_cfg(3'd7, 3'd6, 8'h99);
        push_cfg(3'd0, 3'd7, 8'h01);
        do_start(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        for (int k = 0; k < 100 && !in_run; k++) begin
            tick();
            if (net_cmd === 3'd0) in_run = 1;
        end
        n_cmp++;
        if (!in_run) begin
            n_err++;
            $display("FAIL midrun_reach: run not reached in 100 cycles, required run");
        end
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        n_cmp += 5;
        if (net_cmd !== 3'd5) begin n_err++; $display("FAIL midrun_cmd: got %0d, required 5", net_cmd); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL midrun_busy: got %b, required 0", busy); end
        if (net_in1 !== 1'b0 || net_in2 !== 1'b0) begin
            n_err++; $display("FAIL midrun_in: got %b%b, required 00", net_in1, net_in2);
        end
        if (result_time !== 32'd0) begin n_err++; $display("FAIL midrun_rtime: got %0h, required 0", result_time); end
        if (result !== 1'b0) begin n_err++; $display("FAIL midrun_result: got %b, required 0", result); end
        sb_q.delete();
        bus_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        set_stub(1, 4, 1'b0, 32'd30);
        do_start(1'b1, 1'b1, 1'b0, 32'd30, 1'b0);
        wait_done("after_reset", -1);
        n_cmp++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL after_reset_ready: got %b, required 1", cfg_if.cfg_ready);
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        start            = 1'b0;
        in1_req          = 1'b0;
        in2_req          = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_addr  = '0;
        cfg_if.cfg_cmd   = '0;
        cfg_if.cfg_arg   = '0;
        set_stub(0, 0, 1'b0, 32'd0);
        test_reset();
        test_empty_run();
        test_program_order();
        test_timeout();
        test_cfg_err();
        test_full_and_busy();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
